// File: rtl/uart_rx_16x.sv
// UART receiver: 16x-oversampled start/data/parity/stop sampling into a 16-deep
// first-word-fall-through RX FIFO with registered one-cycle error strobes.
module uart_rx_16x #(
  parameter int unsigned C_DATA_BITS  = 8,
  parameter int unsigned C_USE_PARITY = 0,
  parameter int unsigned C_ODD_PARITY = 0
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   EN_16x_Baud,
  input  logic                   RX,
  input  logic                   Read_RX_FIFO,
  input  logic                   Reset_RX_FIFO,
  output logic [C_DATA_BITS-1:0] RX_Data,
  output logic                   RX_Data_Present,
  output logic                   RX_Buffer_Full,
  output logic                   RX_Frame_Error,
  output logic                   RX_Parity_Error,
  output logic                   RX_Overrun_Error
);

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned CW    = 5;
  localparam int unsigned TW    = 4;
  localparam int unsigned BW    = 4;
  localparam logic [TW-1:0] CENTRE   = TW'(7);
  localparam logic [BW-1:0] LAST_BIT = BW'(C_DATA_BITS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state, state_nxt;
  logic                   rx_meta, rx_s;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [C_DATA_BITS-1:0] shreg;
  logic                   par_bad;
  logic                   centre_c, start_c, clr_bits_c, shift_c, par_c, stop_c;

  logic [C_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]          count, count_nxt;
  logic                   wr_c, rd_c, full_c;
  logic [C_DATA_BITS-1:0] head_c;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  assign centre_c = EN_16x_Baud && (tick_cnt == CENTRE);

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_c    = 1'b0;
    clr_bits_c = 1'b0;
    shift_c    = 1'b0;
    par_c      = 1'b0;
    stop_c     = 1'b0;
    case (state)
      IDLE: begin
        if (EN_16x_Baud && !rx_s) begin
          state_nxt = START;
          start_c   = 1'b1;
        end
      end
      START: begin
        if (centre_c) begin
          if (!rx_s) begin
            state_nxt  = DATA;
            clr_bits_c = 1'b1;
          end else begin
            state_nxt  = IDLE;
          end
        end
      end
      DATA: begin
        if (centre_c) begin
          shift_c = 1'b1;
          if (bit_cnt == LAST_BIT) state_nxt = (C_USE_PARITY != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (centre_c) begin
          par_c     = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (centre_c) begin
          stop_c    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit-timing and shift datapath; every sample lands on tick_cnt == 7
  always_ff @(posedge Clk) begin
    if (Reset) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bad  <= 1'b0;
    end else begin
      if (start_c)          tick_cnt <= '0;
      else if (EN_16x_Baud) tick_cnt <= tick_cnt + TW'(1);
      if (clr_bits_c)       bit_cnt  <= '0;
      else if (shift_c)     bit_cnt  <= bit_cnt + BW'(1);
      if (shift_c)          shreg    <= {rx_s, shreg[C_DATA_BITS-1:1]};
      if (start_c)          par_bad  <= 1'b0;
      else if (par_c)       par_bad  <= ((^shreg) ^ rx_s) != 1'(C_ODD_PARITY);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      RX_Frame_Error   <= 1'b0;
      RX_Parity_Error  <= 1'b0;
      RX_Overrun_Error <= 1'b0;
    end else begin
      RX_Frame_Error   <= stop_c && !rx_s;
      RX_Parity_Error  <= stop_c && par_bad;
      RX_Overrun_Error <= stop_c && full_c;
    end
  end

  // FIFO control; the head register is loaded with the word that will be at
  // the head after this edge, including a write landing in an empty FIFO
  always_comb begin
    full_c = (count == FULL_CNT);
    wr_c   = stop_c && !full_c && !Reset_RX_FIFO;
    rd_c   = Read_RX_FIFO && (count != '0);
    if (Reset_RX_FIFO) begin
      count_nxt  = '0;
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      count_nxt  = count + CW'(wr_c) - CW'(rd_c);
      wr_ptr_nxt = wr_ptr + AW'(wr_c);
      rd_ptr_nxt = rd_ptr + AW'(rd_c);
    end
    if (count_nxt == '0)                  head_c = '0;
    else if (wr_c && rd_ptr_nxt == wr_ptr) head_c = shreg;
    else                                   head_c = mem[rd_ptr_nxt];
  end

  always_ff @(posedge Clk) begin
    if (wr_c) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count           <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      RX_Data         <= '0;
      RX_Data_Present <= 1'b0;
      RX_Buffer_Full  <= 1'b0;
    end else begin
      count           <= count_nxt;
      wr_ptr          <= wr_ptr_nxt;
      rd_ptr          <= rd_ptr_nxt;
      RX_Data         <= head_c;
      RX_Data_Present <= (count_nxt != '0);
      RX_Buffer_Full  <= (count_nxt == FULL_CNT);
    end
  end

endmodule

// File: tb/tb_uart_rx_16x.sv
// Directed bench for uart_rx_16x: 8N1 and 8O1 instances, scoreboard of expected
// FIFO words, strobe pulse counters and boundary checks on the FIFO flags.
module tb_uart_rx_16x;

  logic       clk = 1'b0;
  logic       reset, en, flush;
  logic       rx0, rx1, rd0, rd1;
  logic [7:0] data0, data1;
  logic       pres0, full0, fe0, pe0, oe0;
  logic       pres1, full1, fe1, pe1, oe1;

  int unsigned div = 0;
  int fe_cnt0 = 0, pe_cnt0 = 0, oe_cnt0 = 0;
  int fe_cnt1 = 0, pe_cnt1 = 0, oe_cnt1 = 0;
  int passed = 0, total = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  uart_rx_16x dut0 (
    .Clk(clk), .Reset(reset), .EN_16x_Baud(en), .RX(rx0),
    .Read_RX_FIFO(rd0), .Reset_RX_FIFO(flush),
    .RX_Data(data0), .RX_Data_Present(pres0), .RX_Buffer_Full(full0),
    .RX_Frame_Error(fe0), .RX_Parity_Error(pe0), .RX_Overrun_Error(oe0)
  );

  uart_rx_16x #(.C_DATA_BITS(8), .C_USE_PARITY(1), .C_ODD_PARITY(1)) dut1 (
    .Clk(clk), .Reset(reset), .EN_16x_Baud(en), .RX(rx1),
    .Read_RX_FIFO(rd1), .Reset_RX_FIFO(flush),
    .RX_Data(data1), .RX_Data_Present(pres1), .RX_Buffer_Full(full1),
    .RX_Frame_Error(fe1), .RX_Parity_Error(pe1), .RX_Overrun_Error(oe1)
  );

  always #5 clk = ~clk;

  // 16x tick every 4 Clk
  always @(posedge clk) begin
    div <= (div == 3) ? 0 : div + 1;
    en  <= (div == 3);
  end

  // Count strobe-high cycles: one event must give exactly one high cycle
  always @(negedge clk) begin
    if (fe0 === 1'b1) fe_cnt0++;
    if (pe0 === 1'b1) pe_cnt0++;
    if (oe0 === 1'b1) oe_cnt0++;
    if (fe1 === 1'b1) fe_cnt1++;
    if (pe1 === 1'b1) pe_cnt1++;
    if (oe1 === 1'b1) oe_cnt1++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic ticks(input int n);
    repeat (n * 4) @(negedge clk);
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 0) rx0 = v;
    else            rx1 = v;
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input bit use_par,
                            input logic par, input logic stop);
    drive(which, 1'b0);
    ticks(16);
    for (int i = 0; i < 8; i++) begin
      drive(which, d[i]);
      ticks(16);
    end
    if (use_par) begin
      drive(which, par);
      ticks(16);
    end
    drive(which, stop);
    ticks(16);
  endtask

  // Wait (bounded) for a word, compare it with the scoreboard head, then pop it
  task automatic read_check(input int which, input string tag);
    logic [7:0] exp;
    int n;
    n = 0;
    while (((which == 0) ? pres0 : pres1) !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (which == 0) exp = (exp_q0.size() > 0) ? exp_q0.pop_front() : 8'hxx;
    else            exp = (exp_q1.size() > 0) ? exp_q1.pop_front() : 8'hxx;
    check({tag, "_present"}, 32'((which == 0) ? pres0 : pres1), 32'd1);
    check({tag, "_data"}, 32'((which == 0) ? data0 : data1), 32'(exp));
    if (which == 0) rd0 = 1'b1;
    else            rd1 = 1'b1;
    @(negedge clk);
    rd0 = 1'b0;
    rd1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    rx0 = 1'b1; rx1 = 1'b1; rd0 = 1'b0; rd1 = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_data", 32'(data0), 32'h0);
    check("rst_present", 32'(pres0), 32'h0);
    check("rst_full", 32'(full0), 32'h0);
    check("rst_strobes", 32'({fe0, pe0, oe0, fe1, pe1, oe1}), 32'h0);
    reset = 1'b0;
    ticks(20);

    // 8N1 basic receive and single read
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    exp_q0.push_back(8'hA5);
    ticks(4);
    read_check(0, "a5");
    check("a5_empty_after_read", 32'(pres0), 32'h0);
    check("a5_no_strobes", 32'(fe_cnt0 + pe_cnt0 + oe_cnt0), 32'd0);

    // Glitch shorter than half a bit is rejected
    rx0 = 1'b0;
    ticks(5);
    rx0 = 1'b1;
    ticks(40);
    check("glitch_no_write", 32'(pres0), 32'h0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    exp_q0.push_back(8'h3C);
    ticks(4);
    read_check(0, "after_glitch");

    // Low stop bit: word kept, frame error, then the held-low line restarts
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b0);
    exp_q0.push_back(8'h81);
    check("fe_strobe", 32'(fe_cnt0), 32'd1);
    ticks(24);
    rx0 = 1'b1;
    exp_q0.push_back(8'hFE);
    ticks(200);
    check("fe_single_only", 32'(fe_cnt0), 32'd1);
    read_check(0, "fe_word");
    read_check(0, "restart_word");
    check("fe_no_parity", 32'(pe_cnt0), 32'd0);

    // Odd parity on the second instance
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    exp_q1.push_back(8'h07);
    ticks(4);
    check("par_ok_no_err", 32'(pe_cnt1), 32'd0);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    exp_q1.push_back(8'h07);
    ticks(4);
    check("par_bad_err", 32'(pe_cnt1), 32'd1);
    read_check(1, "par_ok");
    read_check(1, "par_bad");
    check("par_no_frame_err", 32'(fe_cnt1 + oe_cnt1), 32'd0);

    // Fill to 16, then overrun with the 17th
    for (int v = 0; v < 17; v++) begin
      send_frame(0, 8'(v), 1'b0, 1'b0, 1'b1);
      if (v < 16) exp_q0.push_back(8'(v));
      if (v == 14) check("full_at_15", 32'(full0), 32'h0);
      if (v == 15) check("full_at_16", 32'(full0), 32'h1);
    end
    check("overrun_strobe", 32'(oe_cnt0), 32'd1);
    check("overrun_still_full", 32'(full0), 32'h1);
    for (int k = 0; k < 16; k++) begin
      read_check(0, $sformatf("ovr_rd%0d", k));
      if (k == 0) check("full_clears_on_read", 32'(full0), 32'h0);
    end
    check("ovr_drained", 32'(pres0), 32'h0);

    // Reset during data bit 3: frame discarded, no strobes
    fork
      send_frame(0, 8'hFA, 1'b0, 1'b0, 1'b1);
      begin
        ticks(16 + 3 * 16 + 8);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    join
    ticks(40);
    check("midreset_no_write", 32'(pres0), 32'h0);
    check("midreset_no_strobes", 32'(fe_cnt0 + pe_cnt0 + oe_cnt0), 32'd2);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    exp_q0.push_back(8'h5A);
    ticks(4);
    read_check(0, "after_midreset");

    // FIFO flush with 3 words stored while a 4th frame is in flight
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h33, 1'b0, 1'b0, 1'b1);
    check("three_stored", 32'(pres0), 32'h1);
    fork
      send_frame(0, 8'h44, 1'b0, 1'b0, 1'b1);
      begin
        ticks(40);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_present", 32'(pres0), 32'h0);
      end
    join
    exp_q0.push_back(8'h44);
    ticks(4);
    read_check(0, "inflight_after_flush");
    check("flush_final_empty", 32'(pres0), 32'h0);
    check("final_strobes", 32'(fe_cnt0 + pe_cnt0 + oe_cnt0), 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_16x.md
# uart_rx_16x

UART receive core for the AXI UART Lite datapath, the receive-side counterpart of the 16x-oversampled transmitter. It synchronises the serial RX line and detects the start bit. It samples each bit at its centre using the shared EN_16x_Baud tick. Received words are stored in a 16-deep RX FIFO for the register interface, with one-cycle frame, parity and overrun error strobes for the status register.

## Interface
- C_DATA_BITS, 8, data bits per frame, legal values 5 to 8.
- C_USE_PARITY, 0, 1 means a parity bit is expected between the last data bit and the stop bit.
- C_ODD_PARITY, 0, 1 selects odd parity, 0 selects even parity; ignored when C_USE_PARITY = 0.
- Clk  in  1  system clock.
- Reset  in  1  reset Reset, synchronous, active-high; clock Clk.
- EN_16x_Baud  in  1  one-Clk-wide pulse at 16x the baud rate.
- RX  in  1  asynchronous serial input, idle high.
- Read_RX_FIFO  in  1  pops the FIFO head; ignored when the FIFO is empty.
- Reset_RX_FIFO  in  1  synchronous FIFO flush; the receive FSM is not affected.
- RX_Data  out  C_DATA_BITS  FIFO head word; valid while RX_Data_Present = 1; bit 0 is the first bit received.
- RX_Data_Present  out  1  FIFO not empty.
- RX_Buffer_Full  out  1  FIFO holds 16 words.
- RX_Frame_Error  out  1  one-cycle strobe: stop bit sampled low.
- RX_Parity_Error  out  1  one-cycle strobe: parity mismatch; constant 0 when C_USE_PARITY = 0.
- RX_Overrun_Error  out  1  one-cycle strobe: word completed while the FIFO was full.

## Operation
- **RX synchroniser:** two flops, both reset to 1; rx_s is the second flop. All logic uses rx_s only.
- **Tick counter:** 4-bit tick_cnt advances only on EN_16x_Baud and wraps 15 -> 0. It is cleared when entering START.
- **FSM states:** IDLE, START, DATA, PARITY, STOP. Reset enters IDLE.
  - IDLE: a tick with rx_s = 0 moves the FSM to START with tick_cnt = 0.
  - START: at the tick where tick_cnt reaches 7 (start-bit centre), rx_s = 0 moves to DATA and clears bit_cnt. rx_s = 1 is a false start: return to IDLE with no output.
  - DATA: a sample is taken every 16 ticks after the start-bit centre. Each sample shifts rx_s into the MSB of a C_DATA_BITS shift register and shifts right, giving LSB first. After C_DATA_BITS samples, go to PARITY if C_USE_PARITY = 1, else STOP.
  - PARITY: sample one bit. The error condition is XOR(data bits, parity bit) != C_ODD_PARITY.
  - STOP: sample the stop bit, then evaluate the results and return to IDLE on that same tick.
- **Stop-bit results:**
  - The word is written to the FIFO if the FIFO is not full. It is written even with a frame or parity error.
  - If the FIFO is full, the word is dropped, RX_Overrun_Error pulses, and the FIFO contents are unchanged.
  - RX_Frame_Error pulses when the stop sample = 0.
  - RX_Parity_Error pulses when the parity check fails.
  - All three strobes are registered and asserted on the cycle after the stop-sample tick.
  - A low line after a frame error is treated as a new start from IDLE.
- **FIFO:** 16 deep, first-word-fall-through, with a 5-bit occupancy count.
  - Simultaneous write and read when not full: both occur and the count is unchanged.
  - When full, a write is refused even if Read_RX_FIFO is high in the same cycle; the read is still performed.
  - A read when empty is ignored, and the count never underflows.
  - Reset or Reset_RX_FIFO empties the FIFO. A write in the same cycle as Reset_RX_FIFO is lost.
- **Reset mid-frame:** the FSM returns to IDLE, the partial word is discarded, and no strobes are generated.

## Timing
- **Output reset values:**
  - RX_Data = 0.
  - RX_Data_Present = 0.
  - RX_Buffer_Full = 0.
  - All error strobes = 0.
- **Falling-edge latency:** 2 Clk from an RX falling edge to rx_s, plus up to one tick period before it is detected.
- **Sample points:** 8, 24, 40, ... ticks after start detection, i.e. bit centres within ±1 tick.
- **FIFO write:** occurs on the Clk edge after the stop-sample tick.
- **FIFO flags:** RX_Data_Present and RX_Data update on the next edge, 1 Clk write-to-visible.
- **Read:** when Read_RX_FIFO is sampled high, the next word appears on RX_Data on the following edge.
- **Full flag:** RX_Buffer_Full asserts on the same edge as the 16th write.
- **Frame length:** 16 x (1 + C_DATA_BITS + C_USE_PARITY + 1) ticks; the FSM is back in IDLE 8 ticks before the nominal end of the stop bit.

## Test plan
- **8N1 receive:** EN_16x_Baud every 4 Clk. Drive 0xA5 LSB first with a high stop bit. Expect RX_Data = 0xA5, RX_Data_Present = 1, no strobes. A single Read_RX_FIFO pulse then clears RX_Data_Present.
- **Glitch rejection:** drive RX low for 5 ticks, then high. Expect no FIFO write, the FSM returns to IDLE, and a following 0x3C frame is received correctly.
- **Frame error:** send 0x81 with a low stop bit. Expect 0x81 written and a one-cycle RX_Frame_Error pulse. Keep RX low long enough and a new start is detected.
- **Parity (C_USE_PARITY = 1, C_ODD_PARITY = 1):**
  - 0x07 with parity bit 0 gives no error.
  - 0x07 with parity bit 1 gives an RX_Parity_Error pulse, and the data is still written.
- **Overrun:** send 17 frames 0x00..0x10 without reads. After 16 frames RX_Buffer_Full = 1. The 17th frame gives an RX_Overrun_Error pulse. Sixteen reads return 0x00..0x0F in order.
- **Resets:** assert Reset during data bit 3. Expect no write and no strobes, and the next frame 0x5A is received. Assert Reset_RX_FIFO with 3 words stored. Expect RX_Data_Present = 0 next cycle while an in-flight frame still completes and is written.
